// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: state encoding and bus widths.
package dmem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;

    localparam logic [MASK_W-1:0] WMASK_READ = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_arb_rr2.sv
// Two-requester round-robin picker: on a tie the port that did not win last time wins.
module dmem_arb_rr2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] & (~req[1] | last_grant);
        gnt[1] = req[1] & (~req[0] | ~last_grant);
    end

endmodule

// File: rtl/dmem_arb.sv
// Two-port arbiter/sequencer for the data-memory bus; one transaction in flight,
// registered bus request, one-cycle response pulse, watchdog on the response.
//
// state    | meaning
// ST_IDLE  | no transaction; grant and accept a requester
// ST_ISSUE | latched request driven on the bus until mem_i_ready
// ST_WAIT  | waiting for mem_i_rvalid, watchdog counting
module dmem_arb
    import dmem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_i_valid,
    output logic              m0_o_ready,
    input  logic [ADDR_W-1:0] m0_i_addr,
    input  logic [DATA_W-1:0] m0_i_wdata,
    input  logic [MASK_W-1:0] m0_i_wmask,
    output logic              m0_o_rvalid,
    output logic [DATA_W-1:0] m0_o_rdata,
    output logic              m0_o_err,

    input  logic              m1_i_valid,
    output logic              m1_o_ready,
    input  logic [ADDR_W-1:0] m1_i_addr,
    input  logic [DATA_W-1:0] m1_i_wdata,
    input  logic [MASK_W-1:0] m1_i_wmask,
    output logic              m1_o_rvalid,
    output logic [DATA_W-1:0] m1_o_rdata,
    output logic              m1_o_err,

    output logic              mem_o_valid,
    input  logic              mem_i_ready,
    output logic [ADDR_W-1:0] mem_o_addr,
    output logic [MASK_W-1:0] mem_o_wmask,
    output logic [DATA_W-1:0] mem_o_wdata,
    input  logic              mem_i_rvalid,
    input  logic [DATA_W-1:0] mem_i_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state;
    state_e            next_state;
    logic              last_grant;
    logic              gid;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        gnt;
    logic              accept;
    logic              resp_fire;
    logic              resp_err;
    logic [1:0]        rvalid_q;
    logic [ADDR_W-1:0] lat_addr;
    logic [MASK_W-1:0] lat_wmask;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic              err0_q;
    logic              err1_q;

    dmem_arb_rr2 u_rr2 (
        .req        ({m1_i_valid, m0_i_valid}),
        .last_grant (last_grant),
        .gnt        (gnt)
    );

    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        mem_o_valid = 1'b0;
        resp_fire   = 1'b0;
        resp_err    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|gnt) begin
                    accept     = 1'b1;
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_o_valid = 1'b1;
                if (mem_i_ready) next_state = ST_WAIT;
            end
            ST_WAIT: begin
                // A real response beats the watchdog when both land in the same cycle.
                if (mem_i_rvalid) begin
                    resp_fire  = 1'b1;
                    next_state = ST_IDLE;
                end else if (cnt >= CNT_LAST) begin
                    resp_fire  = 1'b1;
                    resp_err   = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Ready is combinational from the valids, so it must be masked while rst is high.
    assign m0_o_ready = accept & gnt[0] & ~rst;
    assign m1_o_ready = accept & gnt[1] & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            gid        <= 1'b0;
            cnt        <= '0;
            lat_addr   <= '0;
            lat_wmask  <= '0;
            lat_wdata  <= '0;
            rvalid_q   <= 2'b00;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
        end else begin
            state    <= next_state;
            rvalid_q <= 2'b00;
            if (accept) begin
                lat_addr   <= gnt[1] ? m1_i_addr  : m0_i_addr;
                lat_wmask  <= gnt[1] ? m1_i_wmask : m0_i_wmask;
                lat_wdata  <= gnt[1] ? m1_i_wdata : m0_i_wdata;
                gid        <= gnt[1];
                last_grant <= gnt[1];
            end
            if (state == ST_ISSUE && mem_i_ready) begin
                cnt <= '0;
            end else if (state == ST_WAIT && cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (resp_fire) begin
                if (gid) begin
                    rvalid_q[1] <= 1'b1;
                    rdata1_q    <= resp_err ? '0 : mem_i_rdata;
                    err1_q      <= resp_err;
                end else begin
                    rvalid_q[0] <= 1'b1;
                    rdata0_q    <= resp_err ? '0 : mem_i_rdata;
                    err0_q      <= resp_err;
                end
            end
        end
    end

    assign mem_o_addr  = lat_addr;
    assign mem_o_wmask = lat_wmask;
    assign mem_o_wdata = lat_wdata;

    assign m0_o_rvalid = rvalid_q[0];
    assign m0_o_rdata  = rdata0_q;
    assign m0_o_err    = err0_q;
    assign m1_o_rvalid = rvalid_q[1];
    assign m1_o_rdata  = rdata1_q;
    assign m1_o_err    = err1_q;

endmodule

// File: tb/tb_dmem_arb.sv
// Self-checking bench for dmem_arb: directed scenarios plus randomized transactions
// checked against a transaction-level model of grant order, bus fields and responses.
module tb_dmem_arb;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_i_valid, m0_o_ready, m0_o_rvalid, m0_o_err;
    logic [31:0] m0_i_addr, m0_i_wdata, m0_o_rdata;
    logic [3:0]  m0_i_wmask;
    logic        m1_i_valid, m1_o_ready, m1_o_rvalid, m1_o_err;
    logic [31:0] m1_i_addr, m1_i_wdata, m1_o_rdata;
    logic [3:0]  m1_i_wmask;
    logic        mem_o_valid, mem_i_ready, mem_i_rvalid;
    logic [31:0] mem_o_addr, mem_o_wdata, mem_i_rdata;
    logic [3:0]  mem_o_wmask;

    int n_checks = 0;
    int n_errors = 0;

    // transaction-level model state
    logic        lg;
    bit          pend;
    int          pend_port;
    logic [31:0] pend_rdata;
    bit          pend_err;

    always #5 clk = ~clk;

    dmem_arb #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_i_valid(m0_i_valid), .m0_o_ready(m0_o_ready), .m0_i_addr(m0_i_addr),
        .m0_i_wdata(m0_i_wdata), .m0_i_wmask(m0_i_wmask), .m0_o_rvalid(m0_o_rvalid),
        .m0_o_rdata(m0_o_rdata), .m0_o_err(m0_o_err),
        .m1_i_valid(m1_i_valid), .m1_o_ready(m1_o_ready), .m1_i_addr(m1_i_addr),
        .m1_i_wdata(m1_i_wdata), .m1_i_wmask(m1_i_wmask), .m1_o_rvalid(m1_o_rvalid),
        .m1_o_rdata(m1_o_rdata), .m1_o_err(m1_o_err),
        .mem_o_valid(mem_o_valid), .mem_i_ready(mem_i_ready), .mem_o_addr(mem_o_addr),
        .mem_o_wmask(mem_o_wmask), .mem_o_wdata(mem_o_wdata), .mem_i_rvalid(mem_i_rvalid),
        .mem_i_rdata(mem_i_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_mem_valid"}, 32'(mem_o_valid), 32'd0);
        check({tag, "_mem_addr"}, mem_o_addr, 32'd0);
        check({tag, "_mem_wmask"}, 32'(mem_o_wmask), 32'd0);
        check({tag, "_mem_wdata"}, mem_o_wdata, 32'd0);
        check({tag, "_ready"}, {30'd0, m1_o_ready, m0_o_ready}, 32'd0);
        check({tag, "_rvalid"}, {30'd0, m1_o_rvalid, m0_o_rvalid}, 32'd0);
        check({tag, "_err"}, {30'd0, m1_o_err, m0_o_err}, 32'd0);
        check({tag, "_rdata0"}, m0_o_rdata, 32'd0);
        check({tag, "_rdata1"}, m1_o_rdata, 32'd0);
    endtask

    task automatic check_resp();
        if (pend) begin
            check("rvalid0", 32'(m0_o_rvalid), 32'(pend_port == 0));
            check("rvalid1", 32'(m1_o_rvalid), 32'(pend_port == 1));
            if (pend_port == 0) begin
                check("rdata0", m0_o_rdata, pend_rdata);
                check("err0", 32'(m0_o_err), 32'(pend_err));
            end else begin
                check("rdata1", m1_o_rdata, pend_rdata);
                check("err1", 32'(m1_o_err), 32'(pend_err));
            end
            pend = 1'b0;
        end else begin
            check("no_rvalid", {30'd0, m1_o_rvalid, m0_o_rvalid}, 32'd0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        m0_i_valid = 1'b0; m1_i_valid = 1'b0;
        mem_i_ready = 1'b0; mem_i_rvalid = 1'b0; mem_i_rdata = 32'd0;
        @(negedge clk);
        #1;
        check_zero_outputs("rst");
        @(negedge clk);
        rst = 1'b0;
        lg = 1'b1;
        pend = 1'b0;
    endtask

    task automatic idle_cycle(input bit stray);
        @(negedge clk);
        m0_i_valid = 1'b0; m1_i_valid = 1'b0;
        mem_i_ready = 1'b0;
        mem_i_rvalid = stray;
        mem_i_rdata = $urandom;
        #1;
        check_resp();
        check("idle_ready", {30'd0, m1_o_ready, m0_o_ready}, 32'd0);
        check("idle_mem_valid", 32'(mem_o_valid), 32'd0);
    endtask

    // One transaction: accept, bus stall of `stall` cycles, response in WAIT cycle `delay`
    // (delay >= TO means the bus never answers). The response pulse is left pending and
    // checked in the next cycle by whichever task runs next.
    task automatic run_txn(input bit v0, input bit v1,
                           input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] k0,
                           input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] k1,
                           input int stall, input int delay, input logic [31:0] bus_rd,
                           input int abort_at);
        int win;
        logic [31:0] ea, ed;
        logic [3:0]  ek;
        win = (v0 && v1) ? (lg ? 0 : 1) : (v0 ? 0 : 1);
        @(negedge clk);
        m0_i_valid = v0; m0_i_addr = a0; m0_i_wdata = d0; m0_i_wmask = k0;
        m1_i_valid = v1; m1_i_addr = a1; m1_i_wdata = d1; m1_i_wmask = k1;
        mem_i_ready = 1'b0; mem_i_rvalid = 1'b0;
        #1;
        check_resp();
        check("ready0", 32'(m0_o_ready), 32'(win == 0));
        check("ready1", 32'(m1_o_ready), 32'(win == 1));
        lg = (win == 1);
        ea = (win == 1) ? a1 : a0;
        ed = (win == 1) ? d1 : d0;
        ek = (win == 1) ? k1 : k0;
        for (int s = 0; s <= stall; s++) begin
            @(negedge clk);
            m0_i_valid = 1'b0; m1_i_valid = 1'b0;
            m0_i_addr = $urandom; m1_i_addr = $urandom;
            m0_i_wdata = $urandom; m1_i_wdata = $urandom;
            m0_i_wmask = 4'($urandom); m1_i_wmask = 4'($urandom);
            mem_i_ready = (s == stall);
            #1;
            check("issue_valid", 32'(mem_o_valid), 32'd1);
            check("issue_addr", mem_o_addr, ea);
            check("issue_wmask", 32'(mem_o_wmask), 32'(ek));
            check("issue_wdata", mem_o_wdata, ed);
        end
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            mem_i_ready = 1'b0;
            mem_i_rvalid = (k == delay);
            mem_i_rdata = (k == delay) ? bus_rd : $urandom;
            #1;
            check("wait_mem_valid", 32'(mem_o_valid), 32'd0);
            check("wait_rvalid", {30'd0, m1_o_rvalid, m0_o_rvalid}, 32'd0);
            if (k == abort_at) begin
                rst = 1'b1;
                m0_i_valid = 1'b1;
                #1;
                check_zero_outputs("abort");
                @(negedge clk);
                rst = 1'b0;
                m0_i_valid = 1'b0;
                mem_i_rvalid = 1'b0;
                lg = 1'b1;
                pend = 1'b0;
                return;
            end
            if (k == delay) break;
        end
        pend = 1'b1;
        pend_port = win;
        pend_rdata = (delay < TO) ? bus_rd : 32'd0;
        pend_err = (delay >= TO);
    endtask

    initial begin
        rst = 1'b1;
        m0_i_valid = 1'b0; m0_i_addr = '0; m0_i_wdata = '0; m0_i_wmask = '0;
        m1_i_valid = 1'b0; m1_i_addr = '0; m1_i_wdata = '0; m1_i_wmask = '0;
        mem_i_ready = 1'b0; mem_i_rvalid = 1'b0; mem_i_rdata = '0;
        lg = 1'b1;
        pend = 1'b0;
        pend_port = 0;
        pend_rdata = '0;
        pend_err = 1'b0;
        do_reset();

        // port 0 read on a zero-wait bus
        run_txn(1, 0, 32'h10, 32'h0, 4'b0000, 32'h0, 32'h0, 4'b0000, 0, 0, 32'hDEAD_BEEF, -1);
        idle_cycle(0);

        // both ports requesting, from reset: grants alternate 0,1,0,1
        do_reset();
        for (int i = 0; i < 4; i++)
            run_txn(1, 1, 32'h100 + 32'(i), $urandom, 4'b0000, 32'h200 + 32'(i), $urandom, 4'b1111,
                    0, 0, $urandom, -1);
        idle_cycle(0);

        // port 1 write with a five-cycle bus stall
        run_txn(0, 1, 32'h0, 32'h0, 4'b0000, 32'h102, 32'h00AB_0000, 4'b0100, 5, 1, 32'h1234_5678, -1);
        idle_cycle(0);

        // bus never answers, then a stray late response
        run_txn(1, 0, 32'h40, 32'h0, 4'b0000, 32'h0, 32'h0, 4'b0000, 0, 99, 32'h0, -1);
        idle_cycle(1);
        idle_cycle(0);

        // response arrives in the same cycle the watchdog expires
        run_txn(1, 0, 32'h44, 32'h0, 4'b0000, 32'h0, 32'h0, 4'b0000, 2, TO - 1, 32'hCAFE_F00D, -1);
        idle_cycle(0);

        // reset during WAIT, then a tie goes to port 0 and a plain read completes
        run_txn(0, 1, 32'h0, 32'h0, 4'b0000, 32'h88, 32'h55, 4'b0011, 0, 99, 32'h0, 1);
        run_txn(1, 1, 32'h20, 32'h0, 4'b0000, 32'h24, 32'h0, 4'b0000, 0, 0, 32'hA5A5_0001, -1);
        run_txn(1, 0, 32'h30, 32'h0, 4'b0000, 32'h0, 32'h0, 4'b0000, 1, 2, 32'h0BAD_F00D, -1);
        idle_cycle(0);

        for (int i = 0; i < 60; i++) begin
            int pat;
            pat = $urandom_range(1, 3);
            run_txn(pat[0], pat[1],
                    $urandom, $urandom, ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom),
                    $urandom, $urandom, ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, TO + 1), $urandom, -1);
            if ($urandom_range(0, 2) == 0) idle_cycle($urandom_range(0, 1) == 1);
        end
        idle_cycle(0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
